// File: rtl/t_line_decoder.sv
// Receive side of a toggle-encoded line: recovers t = q ^ q_prev, hunts for a sync word,
// then assembles FRAME_LEN LSB-first data words and presents them on a valid/ready port.
module t_line_decoder #(
   parameter int unsigned       DATA_W    = 8,
   parameter logic [DATA_W-1:0] SYNC      = 8'hA5,
   parameter int unsigned       FRAME_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              q_line,
   input  logic              din_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_start,
   output logic              frame_done,
   output logic              overrun
);

   localparam int unsigned    BitW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BitW-1:0] LastBit  = BitW'(DATA_W - 1);
   localparam logic [7:0]      LastWord = 8'(FRAME_LEN - 1);

   typedef enum logic [0:0] {StHunt, StData} state_e;

   state_e              state_q, state_d;
   logic                q_prev_q, q_prev_d;
   logic [DATA_W-1:0]   sync_sr_q, sync_sr_d;
   logic [DATA_W-1:0]   data_sr_q, data_sr_d;
   logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]          word_cnt_q, word_cnt_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                frame_start_q, frame_start_d;
   logic                frame_done_q, frame_done_d;
   logic                overrun_q, overrun_d;

   logic                tbit;
   logic [DATA_W-1:0]   sync_next;
   logic [DATA_W-1:0]   word_next;
   logic                word_done;
   logic                frame_end;
   logic                load;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StHunt;
         q_prev_q      <= 1'b0;
         sync_sr_q     <= '0;
         data_sr_q     <= '0;
         bit_cnt_q     <= '0;
         word_cnt_q    <= '0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         q_prev_q      <= q_prev_d;
         sync_sr_q     <= sync_sr_d;
         data_sr_q     <= data_sr_d;
         bit_cnt_q     <= bit_cnt_d;
         word_cnt_q    <= word_cnt_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         overrun_q     <= overrun_d;
      end
   end

   // Next-state logic
   always_comb begin
      tbit      = q_line ^ q_prev_q;
      sync_next = {sync_sr_q[DATA_W-2:0], tbit};
      word_next = {tbit, data_sr_q[DATA_W-1:1]};
      word_done = din_en && (state_q == StData) && (bit_cnt_q == LastBit);
      frame_end = word_done && (word_cnt_q == LastWord);
      load      = word_done && (!dout_valid_q || dout_ready);

      state_d       = state_q;
      q_prev_d      = q_prev_q;
      sync_sr_d     = sync_sr_q;
      data_sr_d     = data_sr_q;
      bit_cnt_d     = bit_cnt_q;
      word_cnt_d    = word_cnt_q;
      dout_d        = dout_q;
      dout_valid_d  = dout_valid_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      overrun_d     = overrun_q;

      if (din_en) begin
         q_prev_d = q_line;
         case (state_q)
            StHunt: begin
               if (sync_next == SYNC) begin
                  state_d       = StData;
                  sync_sr_d     = '0;
                  data_sr_d     = '0;
                  bit_cnt_d     = '0;
                  word_cnt_d    = '0;
                  frame_start_d = 1'b1;
               end else begin
                  sync_sr_d = sync_next;
               end
            end
            StData: begin
               // sync_sr is frozen here so a sync pattern inside data is just data
               data_sr_d = word_next;
               if (bit_cnt_q == LastBit) begin
                  bit_cnt_d  = '0;
                  word_cnt_d = word_cnt_q + 8'd1;
                  if (frame_end) begin
                     state_d      = StHunt;
                     sync_sr_d    = '0;
                     word_cnt_d   = '0;
                     frame_done_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            default: state_d = StHunt;
         endcase
      end

      // A completed word wins over a pending consume; a blocked slot drops it
      if (load) begin
         dout_d       = word_next;
         dout_valid_d = 1'b1;
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
      if (word_done && !load) begin
         overrun_d = 1'b1;
      end
   end

   // Outputs straight from registers
   always_comb begin
      dout        = dout_q;
      dout_valid  = dout_valid_q;
      frame_start = frame_start_q;
      frame_done  = frame_done_q;
      overrun     = overrun_q;
   end

endmodule

// File: tb/tb_t_line_decoder.sv
// Bench for t_line_decoder: directed frames plus randomized frames checked against a
// stream-level model that finds sync words and slices data words from the t-bit sequence.
module tb_t_line_decoder;

   localparam logic [7:0] SYNC_W = 8'hA5;
   localparam int         FLEN   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       q_line;
   logic       din_en;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       frame_start;
   logic       frame_done;
   logic       overrun;

   t_line_decoder #(
      .DATA_W   (8),
      .SYNC     (SYNC_W),
      .FRAME_LEN(FLEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .q_line     (q_line),
      .din_en     (din_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic       qp;
   bit         tx[$];
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int         starts, dones, exp_starts, exp_dones;
   logic       done_valid;
   logic [7:0] done_word;

   // Monitor: accepted words and frame pulses, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (dout_valid && dout_ready) got.push_back(dout);
         if (frame_start) starts++;
         if (frame_done) begin
            dones++;
            done_valid = dout_valid;
            done_word  = dout;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      starts     = 0;
      dones      = 0;
      done_valid = 1'b0;
      done_word  = '0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      din_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      qp  = 1'b0;
      clear_mon();
   endtask

   task automatic push_msb(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) tx.push_back(b[i]);
   endtask

   task automatic push_lsb(input logic [7:0] b);
      for (int i = 0; i < 8; i++) tx.push_back(b[i]);
   endtask

   task automatic send_bit(input bit t);
      din_en = 1'b1;
      q_line = qp ^ t;
      qp     = q_line;
      @(posedge clk);
      #1;
      din_en = 1'b0;
   endtask

   task automatic send_all(input int gmin, input int gmax);
      foreach (tx[i]) begin
         int g;
         g = $urandom_range(gmax, gmin);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         send_bit(tx[i]);
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic nominal_frame(input logic [7:0] w0, w1, w2, w3);
      tx.delete();
      push_msb(SYNC_W);
      push_lsb(w0);
      push_lsb(w1);
      push_lsb(w2);
      push_lsb(w3);
   endtask

   // Stream model: slide an 8-bit window (bits before the current hunt start count as 0),
   // and after each match cut FLEN LSB-first words from the following bits.
   task automatic run_model();
      int  n, pos, hist, w;
      bit  found;
      n          = tx.size();
      pos        = 0;
      hist       = 0;
      exp_starts = 0;
      exp_dones  = 0;
      exp_q.delete();
      while (pos < n) begin
         found = 1'b0;
         for (int p = pos; p < n && !found; p++) begin
            w = 0;
            for (int k = 0; k < 8; k++) begin
               int idx;
               idx = p - 7 + k;
               w   = (w << 1) | ((idx >= hist) ? int'(tx[idx]) : 0);
            end
            if (w == int'(SYNC_W)) begin
               found = 1'b1;
               pos   = p + 1;
            end
         end
         if (!found) pos = n;
         else begin
            exp_starts++;
            for (int j = 0; j < FLEN; j++) begin
               if (pos + 8 <= n) begin
                  w = 0;
                  for (int k = 0; k < 8; k++) w = w | (int'(tx[pos + k]) << k);
                  exp_q.push_back(8'(w));
                  pos = pos + 8;
                  if (j == FLEN - 1) exp_dones++;
               end else begin
                  pos = n;
               end
            end
            hist = pos;
         end
      end
   endtask

   task automatic check_words(input string tag);
      int m;
      check({tag, ".count"}, got.size(), exp_q.size());
      m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < m; i++) check($sformatf("%s.word%0d", tag, i), got[i], exp_q[i]);
   endtask

   task automatic set_exp4(input logic [7:0] w0, w1, w2, w3);
      exp_q.delete();
      exp_q.push_back(w0);
      exp_q.push_back(w1);
      exp_q.push_back(w2);
      exp_q.push_back(w3);
   endtask

   initial begin
      // T1: reset held with an active line sample
      rst        = 1'b1;
      q_line     = 1'b1;
      din_en     = 1'b1;
      dout_ready = 1'b1;
      qp         = 1'b0;
      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      check("t1.dout", dout, 8'h00);
      check("t1.dout_valid", dout_valid, 1'b0);
      check("t1.frame_start", frame_start, 1'b0);
      check("t1.frame_done", frame_done, 1'b0);
      check("t1.overrun", overrun, 1'b0);
      rst    = 1'b0;
      din_en = 1'b0;
      qp     = 1'b0;

      // T2: nominal frame; first bit t=1 goes out as q_line=1 after reset
      nominal_frame(8'h3C, 8'h81, 8'hFF, 8'h00);
      send_all(0, 0);
      set_exp4(8'h3C, 8'h81, 8'hFF, 8'h00);
      check_words("t2");
      check("t2.starts", starts, 1);
      check("t2.dones", dones, 1);
      check("t2.done_valid", done_valid, 1'b1);
      check("t2.done_word", done_word, 8'h00);
      check("t2.overrun", overrun, 1'b0);

      // T3: consumer never ready
      do_reset();
      dout_ready = 1'b0;
      nominal_frame(8'h3C, 8'h81, 8'hFF, 8'h00);
      send_all(0, 0);
      check("t3.accepted", got.size(), 0);
      check("t3.dout_valid", dout_valid, 1'b1);
      check("t3.dout", dout, 8'h3C);
      check("t3.overrun", overrun, 1'b1);
      check("t3.dones", dones, 1);
      check("t3.done_word", done_word, 8'h3C);
      dout_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("t3.drain_count", got.size(), 1);
      if (got.size() > 0) check("t3.drain_word", got[0], 8'h3C);
      check("t3.valid_cleared", dout_valid, 1'b0);
      check("t3.overrun_sticky", overrun, 1'b1);

      // T4: gaps of 1-3 idle cycles between line samples
      do_reset();
      nominal_frame(8'h3C, 8'h81, 8'hFF, 8'h00);
      send_all(1, 3);
      set_exp4(8'h3C, 8'h81, 8'hFF, 8'h00);
      check_words("t4");
      check("t4.starts", starts, 1);
      check("t4.dones", dones, 1);

      // T5: reset 12 data bits into a frame, then a clean frame
      do_reset();
      nominal_frame(8'h3C, 8'h81, 8'hFF, 8'h00);
      while (tx.size() > 8 + 12) void'(tx.pop_back());
      send_all(0, 0);
      check("t5.pre_abort_count", got.size(), 1);
      check("t5.pre_abort_dones", dones, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5.rst_valid", dout_valid, 1'b0);
      check("t5.rst_overrun", overrun, 1'b0);
      check("t5.rst_dout", dout, 8'h00);
      rst = 1'b0;
      qp  = 1'b0;
      clear_mon();
      nominal_frame(8'h3C, 8'h81, 8'hFF, 8'h00);
      send_all(0, 0);
      set_exp4(8'h3C, 8'h81, 8'hFF, 8'h00);
      check_words("t5");
      check("t5.starts", starts, 1);
      check("t5.dones", dones, 1);

      // T6: near-miss A4 before the real sync, A5 inside the data
      do_reset();
      tx.delete();
      push_msb(8'hA4);
      push_msb(SYNC_W);
      push_lsb(8'hA5);
      push_lsb(8'h11);
      push_lsb(8'h22);
      push_lsb(8'h33);
      send_all(0, 0);
      set_exp4(8'hA5, 8'h11, 8'h22, 8'h33);
      check_words("t6");
      check("t6.starts", starts, 1);
      check("t6.dones", dones, 1);

      // T7: random noise, random words, random gaps, against the stream model
      for (int r = 0; r < 4; r++) begin
         int nz;
         do_reset();
         tx.delete();
         nz = $urandom_range(12, 0);
         for (int i = 0; i < nz; i++) tx.push_back(1'($urandom));
         push_msb(SYNC_W);
         for (int j = 0; j < FLEN; j++) push_lsb(8'($urandom));
         for (int i = 0; i < 6; i++) tx.push_back(1'($urandom));
         send_all(0, 2);
         run_model();
         check_words($sformatf("t7.%0d", r));
         check($sformatf("t7.%0d.starts", r), starts, exp_starts);
         check($sformatf("t7.%0d.dones", r), dones, exp_dones);
         check($sformatf("t7.%0d.overrun", r), overrun, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
